// File: rtl/uart_frame_loader.sv
// rtl/uart_frame_loader.sv - UART byte stream to 4-bit frame-buffer pixel loader
// Optional checksum stage enabled by defining UART_FRAME_LOADER_CHECKSUM_EN.
module uart_frame_loader #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         NUM_PIXELS     = 4096,
   parameter int         ADDR_W         = 13,
   parameter int         TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [3:0]        wr_data,
   output logic              busy,
   output logic              frame_done,
   output logic              err
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_W:0]   PIX_END  = (ADDR_W + 1)'(NUM_PIXELS);

`ifdef UART_FRAME_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_WR_HI, S_WR_LO, S_CHECK, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_WR_HI, S_WR_LO, S_DONE} state_t;
`endif

   state_t            state_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [3:0]        wr_data_q;
   logic              frame_done_q;
   logic              err_q;
   logic [ADDR_W:0]   pix_q;
   logic [TMO_W-1:0]  tmo_q;
   logic [3:0]        lo_q;
   logic              ovr_q;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
         pix_q        <= '0;
         tmo_q        <= '0;
         lo_q         <= '0;
         ovr_q        <= 1'b0;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
         csum_q       <= '0;
`endif
      end else begin
         wr_en_q      <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (rx_valid && rx_data == SYNC_BYTE) begin
                  state_q <= S_PAYLOAD;
                  pix_q   <= '0;
                  tmo_q   <= '0;
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
                  csum_q  <= '0;
`endif
               end
            end
            S_PAYLOAD: begin
               if (rx_valid) begin
                  // High nibble goes out now; low nibble is kept for the odd pixel.
                  lo_q      <= rx_data[3:0];
                  tmo_q     <= '0;
                  ovr_q     <= 1'b0;
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= pix_q[ADDR_W-1:0];
                  wr_data_q <= rx_data[7:4];
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
                  csum_q    <= csum_q ^ rx_data;
`endif
                  state_q   <= S_WR_HI;
               end else if (tmo_q == TMO_LAST) begin
                  err_q   <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            S_WR_HI: begin
               wr_en_q   <= 1'b1;
               wr_addr_q <= {pix_q[ADDR_W-1:1], 1'b1};
               wr_data_q <= lo_q;
               pix_q     <= pix_q + (ADDR_W + 1)'(2);
               if (rx_valid) ovr_q <= 1'b1;
               state_q   <= S_WR_LO;
            end
            S_WR_LO: begin
               // A byte arriving mid-pair is dropped and the frame abandoned.
               if (ovr_q || rx_valid) begin
                  err_q   <= 1'b1;
                  state_q <= S_IDLE;
               end else if (pix_q == PIX_END) begin
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
                  state_q      <= S_CHECK;
`else
                  frame_done_q <= 1'b1;
                  state_q      <= S_DONE;
`endif
               end else begin
                  state_q <= S_PAYLOAD;
               end
            end
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
            S_CHECK: begin
               if (rx_valid) begin
                  tmo_q <= '0;
                  if (rx_data == csum_q) begin
                     frame_done_q <= 1'b1;
                     state_q      <= S_DONE;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end else if (tmo_q == TMO_LAST) begin
                  err_q   <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
`endif
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign busy       = (state_q != S_IDLE);
   assign frame_done = frame_done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// tb/tb_uart_frame_loader.sv - directed self-checking bench for uart_frame_loader
// Frame-level checks rely on a negedge write monitor that mirrors the frame buffer.
module tb_uart_frame_loader;

   localparam int         ADDR_W = 13;
   localparam int         NPIX   = 4096;
   localparam int         TMO    = 50;
   localparam logic [7:0] SYNC   = 8'hA5;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [3:0]        wr_data;
   logic              busy;
   logic              frame_done;
   logic              err;

   int vec_cnt = 0;
   int miss_cnt = 0;
   int cyc = 0;
   int wr_cnt = 0;
   int err_cnt = 0;
   int done_cnt = 0;
   int last_wr_cyc = 0;
   int done_cyc = 0;
   logic [3:0] mem [0:NPIX-1];

   uart_frame_loader #(
      .SYNC_BYTE(SYNC), .NUM_PIXELS(NPIX), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .frame_done(frame_done), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         mem[wr_addr] = wr_data;
         wr_cnt++;
         last_wr_cyc = cyc;
      end
      if (err === 1'b1) err_cnt++;
      if (frame_done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   // Entered and left at #1 after a rising edge; leaves room for the write pair.
   task send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task apply_reset();
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task run_frame(input logic [7:0] b, input string tag);
      int w0, e0, d0, bad;
      logic [3:0] want;
      w0 = wr_cnt; e0 = err_cnt; d0 = done_cnt; bad = 0;
      send_byte(SYNC);
      for (int i = 0; i < NPIX / 2; i++) send_byte(b);
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
      send_byte(8'h00);
`endif
      repeat (3) @(posedge clk);
      #1;
      vec_cnt++; if (wr_cnt - w0 !== NPIX) begin miss_cnt++; $display("FAIL %s write count: got %0d want %0d", tag, wr_cnt - w0, NPIX); end
      vec_cnt++; if (err_cnt - e0 !== 0) begin miss_cnt++; $display("FAIL %s err pulses: got %0d want 0", tag, err_cnt - e0); end
      vec_cnt++; if (done_cnt - d0 !== 1) begin miss_cnt++; $display("FAIL %s frame_done pulses: got %0d want 1", tag, done_cnt - d0); end
      vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL %s busy after frame: got %b want 0", tag, busy); end
`ifndef UART_FRAME_LOADER_CHECKSUM_EN
      vec_cnt++; if (done_cyc !== last_wr_cyc + 1) begin miss_cnt++; $display("FAIL %s done latency: got cycle %0d want %0d", tag, done_cyc, last_wr_cyc + 1); end
`endif
      for (int i = 0; i < NPIX; i++) begin
         want = (i % 2 == 0) ? b[7:4] : b[3:0];
         if (mem[i] !== want) bad++;
      end
      vec_cnt++; if (bad !== 0) begin miss_cnt++; $display("FAIL %s buffer contents: got %0d wrong pixels want 0", tag, bad); end
   endtask

   task test_reset();
      apply_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      vec_cnt++; if (wr_en !== 1'b0) begin miss_cnt++; $display("FAIL reset wr_en: got %b want 0", wr_en); end
      vec_cnt++; if (wr_addr !== '0) begin miss_cnt++; $display("FAIL reset wr_addr: got %0d want 0", wr_addr); end
      vec_cnt++; if (wr_data !== 4'h0) begin miss_cnt++; $display("FAIL reset wr_data: got %h want 0", wr_data); end
      vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL reset busy: got %b want 0", busy); end
      vec_cnt++; if (frame_done !== 1'b0) begin miss_cnt++; $display("FAIL reset frame_done: got %b want 0", frame_done); end
      vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL reset err: got %b want 0", err); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task test_full_frame();
      apply_reset();
      run_frame(8'h3C, "full_3c");
   endtask

   task test_presync();
      int w0;
      logic [7:0] b;
      apply_reset();
      w0 = wr_cnt;
      for (int i = 0; i < 3; i++) begin
         b = (i == 0) ? 8'h00 : (i == 1) ? 8'h11 : 8'h5A;
         send_byte(b);
         vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL presync busy byte %h: got %b want 0", b, busy); end
      end
      vec_cnt++; if (wr_cnt - w0 !== 0) begin miss_cnt++; $display("FAIL presync writes: got %0d want 0", wr_cnt - w0); end
      send_byte(SYNC);
      vec_cnt++; if (busy !== 1'b1) begin miss_cnt++; $display("FAIL sync busy: got %b want 1", busy); end
      rx_data = 8'h12; rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      vec_cnt++; if (wr_en !== 1'b1 || wr_addr !== 13'd0 || wr_data !== 4'h1) begin miss_cnt++; $display("FAIL first hi write: got en=%b addr=%0d data=%h want en=1 addr=0 data=1", wr_en, wr_addr, wr_data); end
      @(posedge clk); #1;
      vec_cnt++; if (wr_en !== 1'b1 || wr_addr !== 13'd1 || wr_data !== 4'h2) begin miss_cnt++; $display("FAIL first lo write: got en=%b addr=%0d data=%h want en=1 addr=1 data=2", wr_en, wr_addr, wr_data); end
      @(posedge clk); #1;
      vec_cnt++; if (wr_en !== 1'b0 || busy !== 1'b1) begin miss_cnt++; $display("FAIL after pair: got en=%b busy=%b want en=0 busy=1", wr_en, busy); end
      apply_reset();
   endtask

   task test_timeout();
      int w0, e0, d0;
      apply_reset();
      w0 = wr_cnt; e0 = err_cnt; d0 = done_cnt;
      send_byte(SYNC);
      for (int i = 0; i < 10; i++) send_byte(8'h77);
      repeat (TMO - 1) @(posedge clk);
      #1;
      vec_cnt++; if (err !== 1'b0 || busy !== 1'b1) begin miss_cnt++; $display("FAIL timeout early: got err=%b busy=%b want err=0 busy=1", err, busy); end
      @(posedge clk); #1;
      vec_cnt++; if (err !== 1'b1 || busy !== 1'b0) begin miss_cnt++; $display("FAIL timeout fire: got err=%b busy=%b want err=1 busy=0", err, busy); end
      @(posedge clk); #1;
      vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL timeout pulse width: got err=%b want 0", err); end
      vec_cnt++; if (wr_cnt - w0 !== 20) begin miss_cnt++; $display("FAIL timeout writes: got %0d want 20", wr_cnt - w0); end
      vec_cnt++; if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin miss_cnt++; $display("FAIL timeout pulses: got err=%0d done=%0d want err=1 done=0", err_cnt - e0, done_cnt - d0); end
      run_frame(8'h96, "after_timeout");
   endtask

   task test_overrun();
      int w0, e0, d0;
      apply_reset();
      w0 = wr_cnt; e0 = err_cnt; d0 = done_cnt;
      send_byte(SYNC);
      rx_data = 8'hAB; rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_data = 8'hCD;
      vec_cnt++; if (wr_en !== 1'b1 || wr_addr !== 13'd0 || wr_data !== 4'hA) begin miss_cnt++; $display("FAIL overrun hi write: got en=%b addr=%0d data=%h want en=1 addr=0 data=a", wr_en, wr_addr, wr_data); end
      @(posedge clk); #1;
      rx_valid = 1'b0;
      vec_cnt++; if (wr_en !== 1'b1 || wr_addr !== 13'd1 || wr_data !== 4'hB) begin miss_cnt++; $display("FAIL overrun lo write: got en=%b addr=%0d data=%h want en=1 addr=1 data=b", wr_en, wr_addr, wr_data); end
      @(posedge clk); #1;
      vec_cnt++; if (err !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin miss_cnt++; $display("FAIL overrun exit: got err=%b busy=%b en=%b want err=1 busy=0 en=0", err, busy, wr_en); end
      @(posedge clk); #1;
      send_byte(8'h55);
      vec_cnt++; if (wr_cnt - w0 !== 2) begin miss_cnt++; $display("FAIL overrun writes: got %0d want 2", wr_cnt - w0); end
      vec_cnt++; if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin miss_cnt++; $display("FAIL overrun pulses: got err=%0d done=%0d want err=1 done=0", err_cnt - e0, done_cnt - d0); end
      vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL overrun idle busy: got %b want 0", busy); end
   endtask

   task test_reset_midframe();
      int e0, d0;
      apply_reset();
      e0 = err_cnt; d0 = done_cnt;
      send_byte(SYNC);
      for (int i = 0; i < 99; i++) send_byte(8'h42);
      rx_data = 8'h42; rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      vec_cnt++; if (wr_en !== 1'b1 || wr_addr !== 13'd198) begin miss_cnt++; $display("FAIL byte 100 write: got en=%b addr=%0d want en=1 addr=198", wr_en, wr_addr); end
      rst = 1'b1;
      @(posedge clk); #1;
      vec_cnt++; if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== 4'h0) begin miss_cnt++; $display("FAIL midframe reset write port: got en=%b addr=%0d data=%h want 0 0 0", wr_en, wr_addr, wr_data); end
      vec_cnt++; if (busy !== 1'b0 || err !== 1'b0 || frame_done !== 1'b0) begin miss_cnt++; $display("FAIL midframe reset status: got busy=%b err=%b done=%b want 0 0 0", busy, err, frame_done); end
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vec_cnt++; if (err_cnt - e0 !== 0 || done_cnt - d0 !== 0) begin miss_cnt++; $display("FAIL midframe reset pulses: got err=%0d done=%0d want 0 0", err_cnt - e0, done_cnt - d0); end
      send_byte(SYNC);
      rx_data = 8'hE7; rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      vec_cnt++; if (wr_en !== 1'b1 || wr_addr !== 13'd0 || wr_data !== 4'hE) begin miss_cnt++; $display("FAIL restart hi write: got en=%b addr=%0d data=%h want en=1 addr=0 data=e", wr_en, wr_addr, wr_data); end
      @(posedge clk); #1;
      vec_cnt++; if (wr_en !== 1'b1 || wr_addr !== 13'd1 || wr_data !== 4'h7) begin miss_cnt++; $display("FAIL restart lo write: got en=%b addr=%0d data=%h want en=1 addr=1 data=7", wr_en, wr_addr, wr_data); end
      apply_reset();
   endtask

`ifdef UART_FRAME_LOADER_CHECKSUM_EN
   task test_checksum();
      int e0, d0;
      apply_reset();
      e0 = err_cnt; d0 = done_cnt;
      send_byte(SYNC);
      for (int i = 0; i < NPIX / 2; i++) send_byte(8'h01);
      send_byte(8'h00);
      repeat (3) @(posedge clk);
      #1;
      vec_cnt++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin miss_cnt++; $display("FAIL checksum match: got done=%0d err=%0d want done=1 err=0", done_cnt - d0, err_cnt - e0); end
      e0 = err_cnt; d0 = done_cnt;
      send_byte(SYNC);
      for (int i = 0; i < NPIX / 2; i++) send_byte(8'h01);
      send_byte(8'h01);
      repeat (3) @(posedge clk);
      #1;
      vec_cnt++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin miss_cnt++; $display("FAIL checksum mismatch: got done=%0d err=%0d want done=0 err=1", done_cnt - d0, err_cnt - e0); end
      vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL checksum mismatch busy: got %b want 0", busy); end
   endtask
`endif

   initial begin
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      test_reset();
      test_full_frame();
      test_presync();
      test_timeout();
      test_overrun();
      test_reset_midframe();
`ifdef UART_FRAME_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

// File: doc/uart_frame_loader.md
Name: uart_frame_loader

Overview:
- Upstream stage of the LCD DMD video generator.
- Parses a byte stream from the UART receiver into 4-bit greyscale pixels.
- Writes the pixels into the single-port frame-buffer BRAM that the video generator scans out; the address is row-major, y*128 + x.
- Frames are framed by a sync byte and carry two pixels per byte. An inter-byte timeout recovers the parser from a truncated transfer.

Parameters:
- SYNC_BYTE, 8'hA5, header byte that starts a frame.
- NUM_PIXELS, 4096, pixels per frame (128 x 32). Must be even and ≤ 2^ADDR_W.
- ADDR_W, 13, frame-buffer address width.
- TIMEOUT_CYCLES, 1000000, maximum clk cycles allowed between payload bytes before abort.

Ports:
- clk  in  1  system clock; the same clock as the frame buffer and UART.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte; valid only while rx_valid is high.
- rx_valid  in  1  one-cycle strobe from the UART receiver (RxD_data_ready).
- wr_en  out  1  frame-buffer write enable.
- wr_addr  out  ADDR_W  frame-buffer write address.
- wr_data  out  4  pixel value.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes successfully.
- err  out  1  one-cycle pulse on overrun, timeout or checksum failure.

Behaviour:
- Reset is synchronous and active-high. On rst: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, err=0, pixel counter=0, timeout counter=0.
- States: IDLE, PAYLOAD, WR_HI, WR_LO, CHECK (only with the optional feature), DONE.
- IDLE:
  - rx_valid with rx_data==SYNC_BYTE -> PAYLOAD; clear pixel counter and timeout counter.
  - Any other byte is ignored.
- PAYLOAD, byte accepted at cycle N:
  - Latch the byte; go to WR_HI.
  - Cycle N+1: wr_en=1, wr_addr=pix, wr_data=byte[7:4].
  - Cycle N+2 (WR_LO): wr_en=1, wr_addr=pix+1, wr_data=byte[3:0]; pix += 2.
  - The high nibble is always the even (left) pixel.
- After WR_LO:
  - pix==NUM_PIXELS -> DONE (or CHECK when the feature is enabled).
  - Otherwise -> PAYLOAD.
- Overrun: rx_valid asserted while in WR_HI or WR_LO.
  - The current write pair still completes.
  - err pulses in the WR_LO exit cycle; state -> IDLE.
  - The offending byte is dropped.
- Timeout: in PAYLOAD/CHECK, the counter increments each cycle and resets on rx_valid.
  - When it reaches TIMEOUT_CYCLES-1: err pulses for 1 cycle; state -> IDLE.
  - Pixels already written remain in the buffer.
- DONE: frame_done=1 for exactly one cycle; state -> IDLE.
- wr_en is high only in WR_HI/WR_LO. wr_addr and wr_data hold their last values otherwise.
- A SYNC_BYTE value received inside the payload is treated as pixel data; there is no resync mid-frame.
- rst asserted mid-frame aborts immediately. No err or frame_done is produced.
- Pixel counter width is ADDR_W+1, so NUM_PIXELS==2^ADDR_W does not wrap before the comparison.

Optional Feature:
- Macro: UART_FRAME_LOADER_CHECKSUM_EN.
- With the macro defined:
  - A running XOR of all payload bytes is kept, cleared on sync.
  - After the last WR_LO -> CHECK; the next byte is compared with the XOR.
  - Match -> DONE (frame_done). Mismatch -> err pulse, state -> IDLE, no frame_done.
  - The timeout applies in CHECK.
- Without the macro: the CHECK state and the XOR register are absent, and WR_LO goes directly to DONE.

Test Plan:
- Reset, then sync 0xA5 followed by 2048 bytes of 0x3C -> 4096 writes; even addresses carry 3, odd addresses carry C. One frame_done one cycle after the final write; err never asserts.
- Bytes 0x00, 0x11, 0x5A before sync -> no wr_en and busy=0. After 0xA5 followed by 0x12 -> wr_addr 0 gets data 1 at N+1, wr_addr 1 gets data 2 at N+2.
- Sync, 10 bytes, then idle for TIMEOUT_CYCLES (set to 50) -> err pulses once, busy drops, no frame_done. A following full frame loads from address 0.
- Sync, byte 0xAB, second rx_valid in the WR_HI cycle -> writes (0,A), (1,B) complete; err pulses; state returns to IDLE; the dropped byte is never written.
- rst pulsed after 100 payload bytes -> all outputs return to reset values next cycle. The next sync restarts at wr_addr 0.
- With UART_FRAME_LOADER_CHECKSUM_EN, a payload of all 0x01 bytes:
  - The XOR of 2048 bytes of 0x01 is 0x00.
  - Checksum byte 0x00 -> frame_done.
  - Checksum byte 0x01 -> err pulse and no frame_done.
